// File: rtl/ram_stream_reader.sv
// DEPTH x WIDTH synchronous RAM with a host write port and a valid/ready burst-read engine.
// Define RAM_INIT_FILE_EN to add the INIT_FILE parameter.
module ram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
`ifdef RAM_INIT_FILE_EN
    parameter string INIT_FILE = "ram_init.hex",
`endif
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] addr, addr_n;
    logic [LEN_W-1:0]  remaining, remaining_n;
    logic              err_q, err_n;

    // Memory is never reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_X))
            mem[waddr] <= wdata;
    end

    // out_data doubles as the RAM read register, so a same-cycle write yields old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            err_q     <= err_n;
            if (state == FETCH)
                out_data <= mem[addr];
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        err_n       = err_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if ({1'b0, start_addr} >= DEPTH_X) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else if (length == '0) begin
                        err_n   = 1'b0;
                        state_n = DONE;
                    end else begin
                        err_n       = 1'b0;
                        addr_n      = start_addr;
                        remaining_n = length;
                        state_n     = FETCH;
                    end
                end
            end
            FETCH: state_n = VALID;
            VALID: begin
                if (out_ready) begin
                    remaining_n = remaining - LEN_W'(1);
                    addr_n      = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
                    state_n     = (remaining == LEN_W'(1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_valid = (state == VALID);
    assign out_last  = (state == VALID) && (remaining == LEN_W'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && err_q;

endmodule
